// File: rtl/timing_violation_logger.sv
// Timestamped event logger for the timing-check aggregator's violation pulses.
// Events land in a first-word-fall-through FIFO. Drops on full are counted and flagged on the next entry.
module timing_violation_logger #(
    parameter int N_MODULES = 8,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_MODULES-1:0]   viol_vec,
    input  logic                   viol_valid,
    input  logic                   clear,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [N_MODULES-1:0]   evt_mask,
    output logic [TS_W-1:0]        evt_ts,
    output logic                   evt_ovf,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [15:0]            drop_count,
    output logic                   irq,
    input  logic                   irq_ack
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [N_MODULES-1:0] mask;
        logic [TS_W-1:0]      ts;
        logic                 ovf;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [TS_W-1:0] ts;
    logic          pending_ovf;
    logic          push_req, pop, full, push_ok, drop;

    // clear takes precedence: nothing enters or leaves the FIFO in a clear cycle
    assign push_req = viol_valid && (|viol_vec) && !clear;
    assign pop      = evt_valid && evt_ready && !clear;
    assign full     = (level == (AW+1)'(DEPTH));
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && !push_ok;

    assign head       = mem[rd_ptr];
    assign evt_valid  = (level != '0);
    assign evt_mask   = evt_valid ? head.mask : '0;
    assign evt_ts     = evt_valid ? head.ts   : '0;
    assign evt_ovf    = evt_valid ? head.ovf  : 1'b0;
    assign fifo_level = level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ts <= '0;
        else     ts <= ts + 1'b1;
    end

    // storage needs no reset; reads are masked by evt_valid
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= '{mask: viol_vec, ts: ts, ovf: pending_ovf};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            pending_ovf <= 1'b0;
            drop_count  <= '0;
            irq         <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            pending_ovf <= 1'b0;
            drop_count  <= '0;
            irq         <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)      level <= level + 1'b1;
            else if (pop && !push_ok) level <= level - 1'b1;

            if (drop)         pending_ovf <= 1'b1;
            else if (push_ok) pending_ovf <= 1'b0;

            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;

            // a new event outranks a same-cycle acknowledge
            if (push_ok || drop) irq <= 1'b1;
            else if (irq_ack)    irq <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timing_violation_logger.sv
// Directed bench with an expected-entry queue; a forked monitor checks every popped entry.
// A second instance with a 4-bit timestamp shares all inputs to exercise wrap-around.
module tb_timing_violation_logger;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  viol_vec = '0;
    logic        viol_valid = 1'b0, clear = 1'b0, evt_ready = 1'b0, irq_ack = 1'b0;

    logic        evt_valid, evt_ovf, irq;
    logic [7:0]  evt_mask;
    logic [23:0] evt_ts;
    logic [4:0]  fifo_level;
    logic [15:0] drop_count;

    logic        t4_valid, t4_ovf, t4_irq;
    logic [7:0]  t4_mask;
    logic [3:0]  t4_ts;
    logic [4:0]  t4_level;
    logic [15:0] t4_drop;

    typedef struct packed {
        logic [7:0]  mask;
        logic [23:0] ts;
        logic        ovf;
    } exp_t;

    exp_t        q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [23:0] model_ts;

    timing_violation_logger #(.N_MODULES(8), .DEPTH(16), .TS_W(24)) dut (
        .clk(clk), .rst(rst), .viol_vec(viol_vec), .viol_valid(viol_valid), .clear(clear),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_mask(evt_mask), .evt_ts(evt_ts),
        .evt_ovf(evt_ovf), .fifo_level(fifo_level), .drop_count(drop_count), .irq(irq),
        .irq_ack(irq_ack)
    );

    timing_violation_logger #(.N_MODULES(8), .DEPTH(16), .TS_W(4)) dut4 (
        .clk(clk), .rst(rst), .viol_vec(viol_vec), .viol_valid(viol_valid), .clear(clear),
        .evt_valid(t4_valid), .evt_ready(evt_ready), .evt_mask(t4_mask), .evt_ts(t4_ts),
        .evt_ovf(t4_ovf), .fifo_level(t4_level), .drop_count(t4_drop), .irq(t4_irq),
        .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) model_ts <= '0;
        else     model_ts <= model_ts + 24'd1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic [7:0] m, input bit acc, input bit ovf, input bit clr = 1'b0);
        viol_vec   = m;
        viol_valid = 1'b1;
        clear      = clr;
        if (clr) q.delete();
        if (acc) q.push_back('{mask: m, ts: model_ts, ovf: ovf});
        tick();
        viol_valid = 1'b0;
        viol_vec   = '0;
        clear      = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        evt_ready = 1'b1;
        while (evt_valid && n < 40) begin
            tick();
            n++;
        end
        evt_ready = 1'b0;
        chk("drain_empty", {31'd0, evt_valid}, 32'd0);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !clear && evt_valid && evt_ready) begin
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL pop_unexpected: got mask %0h ts %0h, expected no entry", evt_mask, evt_ts);
                end else begin
                    e = q.pop_front();
                    chk("pop_mask_ts", {evt_mask, evt_ts}, {e.mask, e.ts});
                    chk("pop_ovf", {31'd0, evt_ovf}, {31'd0, e.ovf});
                    chk("pop_ts4", {19'd0, t4_mask, t4_ts, t4_ovf}, {19'd0, e.mask, e.ts[3:0], e.ovf});
                end
            end
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_ctl"}, {24'd0, evt_valid, evt_ovf, irq, fifo_level}, 32'd0);
        chk({name, "_data"}, {evt_mask, evt_ts}, 32'd0);
        chk({name, "_drop"}, {16'd0, drop_count}, 32'd0);
    endtask

    initial begin
        fork
            monitor();
        join_none

        #12;
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // single event at ts=5
        repeat (5) tick();
        ev(8'h04, 1'b1, 1'b0);
        chk("single_valid", {31'd0, evt_valid}, 32'd1);
        chk("single_mask", {24'd0, evt_mask}, 32'h04);
        chk("single_ts", {8'd0, evt_ts}, 32'd5);
        chk("single_ovf", {31'd0, evt_ovf}, 32'd0);
        chk("single_level", {27'd0, fifo_level}, 32'd1);
        chk("single_irq", {31'd0, irq}, 32'd1);
        drain();
        chk("drained_level", {27'd0, fifo_level}, 32'd0);

        // irq ack alone, then ack coincident with an event
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("ack_clears_irq", {31'd0, irq}, 32'd0);
        irq_ack = 1'b1;
        ev(8'h40, 1'b1, 1'b0);
        irq_ack = 1'b0;
        chk("ack_vs_set_irq", {31'd0, irq}, 32'd1);
        drain();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;

        // valid with empty vector is ignored
        ev(8'h00, 1'b0, 1'b0);
        chk("zero_vec_level", {27'd0, fifo_level}, 32'd0);
        chk("zero_vec_irq", {31'd0, irq}, 32'd0);

        // fill 16, drop 2
        for (int i = 0; i < 18; i++) ev(8'(i + 1), i < 16, 1'b0);
        chk("full_level", {27'd0, fifo_level}, 32'd16);
        chk("full_drop", {16'd0, drop_count}, 32'd2);
        chk("full_irq", {31'd0, irq}, 32'd1);
        chk("full_head", {24'd0, evt_mask}, 32'h01);
        chk("t4_full", {10'd0, t4_valid, t4_irq, t4_level, t4_drop}, {10'd0, 1'b1, 1'b1, 5'd16, 16'd2});
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("pop_one_level", {27'd0, fifo_level}, 32'd15);
        ev(8'h81, 1'b1, 1'b1);
        chk("refill_level", {27'd0, fifo_level}, 32'd16);

        // full with simultaneous push and pop
        evt_ready = 1'b1;
        ev(8'h22, 1'b1, 1'b0);
        evt_ready = 1'b0;
        chk("pushpop_level", {27'd0, fifo_level}, 32'd16);
        chk("pushpop_drop", {16'd0, drop_count}, 32'd2);
        chk("pushpop_head", {24'd0, evt_mask}, 32'h03);
        drain();

        // clear coincident with an event, with a pending overflow outstanding
        for (int i = 0; i < 17; i++) ev(8'(i + 8'h30), i < 16, 1'b0);
        chk("pre_clear_drop", {16'd0, drop_count}, 32'd3);
        ev(8'h55, 1'b0, 1'b0, 1'b1);
        chk("clear_level", {27'd0, fifo_level}, 32'd0);
        chk("clear_valid", {31'd0, evt_valid}, 32'd0);
        chk("clear_drop", {16'd0, drop_count}, 32'd0);
        chk("clear_irq", {31'd0, irq}, 32'd0);
        ev(8'h0F, 1'b1, 1'b0);
        chk("post_clear_ovf", {31'd0, evt_ovf}, 32'd0);
        drain();

        // async reset mid-drain
        for (int i = 0; i < 7; i++) ev(8'(i + 8'hA0), 1'b1, 1'b0);
        chk("pre_rst_level", {27'd0, fifo_level}, 32'd7);
        evt_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        q.delete();
        chk_zero("async_rst");
        evt_ready = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        tick();
        ev(8'h01, 1'b1, 1'b0);
        chk("ts_restart", {8'd0, evt_ts}, 32'd2);
        drain();

        // 4-bit timestamp wraps 15 -> 0
        while (model_ts != 24'd15) tick();
        ev(8'h11, 1'b1, 1'b0);
        ev(8'h12, 1'b1, 1'b0);
        chk("wrap_ts4_a", {28'd0, t4_ts}, 32'd15);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        chk("wrap_ts4_b", {28'd0, t4_ts}, 32'd0);
        chk("wrap_ts24_b", {8'd0, evt_ts}, 32'd16);
        drain();

        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
